sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 19 +
 rtl/arb_starve_cnt.sv | 34 +++
 rtl/sram_port_arbiter.sv | 99 +++++++++
 tb/tb_sram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: response-tracker states and
// the default starvation threshold.
package sram_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        RSP_IDLE   = 2'd0,
        RSP_IF_RD  = 2'd1,
        RSP_MEM_RD = 2'd2,
        RSP_MEM_WR = 2'd3
    } rsp_state_e;

    // Width needed to hold 0..limit; a limit of 0 still gets one bit.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles in which ifetch asks but is refused; the flag
// hands the next contested cycle to ifetch.
module arb_starve_cnt
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic if_req,
    input  logic if_gnt,
    output logic starve_flag
);

    localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_p1 <= '0;
        end else if (if_req && !if_gnt) begin
            if (cnt_p1 != LIMIT) begin
                cnt_p1 <= cnt_p1 + 1'b1;
            end
        end else begin
            cnt_p1 <= '0;
        end
    end

    assign starve_flag = (cnt_p1 == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port data SRAM between instruction fetch and the memory
// stage; mem has priority except when ifetch has been starved too long.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,

    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    logic       starve_flag;
    logic       grant_if;
    logic       grant_mem;
    rsp_state_e rsp_state_p1;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .if_req      (if_req),
        .if_gnt      (grant_if),
        .starve_flag (starve_flag)
    );

    // Stage p0: grant decision and SRAM command, combinational from requests.
    // resetn gates every grant so outputs stay quiet during reset without a clock.
    always_comb begin
        grant_mem = resetn && mem_req && !(starve_flag && if_req);
        grant_if  = resetn && if_req && !grant_mem;
    end

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (grant_mem) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = mem_wen;
            data_sram_addr  = mem_addr;
            data_sram_wdata = mem_wdata;
        end else if (grant_if) begin
            data_sram_en    = 1'b1;
            data_sram_addr  = if_addr;
        end
    end

    assign if_gnt    = grant_if;
    assign mem_gnt   = grant_mem;
    assign mem_stall = resetn && mem_req && !grant_mem;

    // Stage p1: remember who owns the SRAM read data arriving next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_state_p1 <= RSP_IDLE;
        end else if (grant_if) begin
            rsp_state_p1 <= RSP_IF_RD;
        end else if (grant_mem) begin
            rsp_state_p1 <= (mem_wen == 4'h0) ? RSP_MEM_RD : RSP_MEM_WR;
        end else begin
            rsp_state_p1 <= RSP_IDLE;
        end
    end

    assign if_rvalid  = (rsp_state_p1 == RSP_IF_RD);
    assign mem_rvalid = (rsp_state_p1 == RSP_MEM_RD);
    assign if_rdata   = if_rvalid  ? data_sram_rdata : 32'h0;
    assign mem_rdata  = mem_rvalid ? data_sram_rdata : 32'h0;

    a_one_grant : assert property (@(posedge clk) disable iff (!resetn)
        !(grant_if && grant_mem));

    a_one_rvalid : assert property (@(posedge clk) disable iff (!resetn)
        !(if_rvalid && mem_rvalid));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a transaction-level model predicts
// grants and read responses; a monitor pops expected responses as they appear.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid, mem_stall;
    logic [31:0] mem_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'h0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_gnt          (if_gnt),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .mem_req         (mem_req),
        .mem_wen         (mem_wen),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .mem_stall       (mem_stall),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] salt(input logic [7:0] i);
        return 32'h9E37_79B9 * ({24'h0, i} + 32'd1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM on the DUT's shared port; storage is kept XOR-salted
    // so that its initial contents are a non-trivial pattern.
    logic [31:0] sram_mem [256] = '{default: 32'h0};

    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen != 4'h0)
                sram_mem[data_sram_addr[9:2]] <= merge(sram_mem[data_sram_addr[9:2]] ^ salt(data_sram_addr[9:2]),
                                                       data_sram_wdata, data_sram_wen) ^ salt(data_sram_addr[9:2]);
            else
                data_sram_rdata <= sram_mem[data_sram_addr[9:2]] ^ salt(data_sram_addr[9:2]);
        end
    end

    // Reference model state: memory image and consecutive-refusal count.
    logic [31:0] ref_mem [256];
    int          starve = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t exp_q[$];

    // Monitor: every read response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (if_rvalid || mem_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'h0, if_rvalid, mem_rvalid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {30'h0, if_rvalid, mem_rvalid}, e.is_if ? 32'h2 : 32'h1);
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                chk("rsp_data", e.is_if ? if_rdata : mem_rdata, e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            chk("missing_rvalid", 32'h0, 32'h1);
            void'(exp_q.pop_front());
        end
        if (!if_rvalid)  chk("if_rdata_idle", if_rdata, 32'h0);
        if (!mem_rvalid) chk("mem_rdata_idle", mem_rdata, 32'h0);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},     32'(if_gnt), 32'h0);
        chk({tag, "_if_rvalid"},  32'(if_rvalid), 32'h0);
        chk({tag, "_if_rdata"},   if_rdata, 32'h0);
        chk({tag, "_mem_gnt"},    32'(mem_gnt), 32'h0);
        chk({tag, "_mem_rvalid"}, 32'(mem_rvalid), 32'h0);
        chk({tag, "_mem_rdata"},  mem_rdata, 32'h0);
        chk({tag, "_mem_stall"},  32'(mem_stall), 32'h0);
        chk({tag, "_sram_en"},    32'(data_sram_en), 32'h0);
        chk({tag, "_sram_wen"},   32'(data_sram_wen), 32'h0);
        chk({tag, "_sram_addr"},  data_sram_addr, 32'h0);
        chk({tag, "_sram_wdata"}, data_sram_wdata, 32'h0);
    endtask

    // One clock of stimulus: apply requests, predict the outcome, check the
    // SRAM command, and queue the read response expected next cycle.
    task automatic drive_cycle(input logic ir, input logic [31:0] ia,
                               input logic mr, input logic [3:0] mw,
                               input logic [31:0] ma, input logic [31:0] md,
                               output logic got_if, output logic got_mem);
        logic exp_mem, exp_if;
        rsp_t e;
        @(posedge clk);
        #1;
        if_req    = ir;
        if_addr   = ia;
        mem_req   = mr;
        mem_wen   = mw;
        mem_addr  = ma;
        mem_wdata = md;
        exp_mem = mr && !(ir && starve == LIMIT);
        exp_if  = ir && !exp_mem;
        #3;
        chk("if_gnt", 32'(if_gnt), 32'(exp_if));
        chk("mem_gnt", 32'(mem_gnt), 32'(exp_mem));
        chk("mem_stall", 32'(mem_stall), 32'(mr && !exp_mem));
        chk("sram_en", 32'(data_sram_en), 32'(exp_if || exp_mem));
        chk("sram_addr", data_sram_addr, exp_mem ? ma : (exp_if ? ia : 32'h0));
        chk("sram_wen", 32'(data_sram_wen), exp_mem ? 32'(mw) : 32'h0);
        chk("sram_wdata", data_sram_wdata, exp_mem ? md : 32'h0);
        if (exp_mem && mw != 4'h0) begin
            ref_mem[ma[9:2]] = merge(ref_mem[ma[9:2]], md, mw);
        end else if (exp_mem || exp_if) begin
            e.is_if = exp_if;
            e.data  = exp_if ? ref_mem[ia[9:2]] : ref_mem[ma[9:2]];
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
        starve  = (ir && !exp_if) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        got_if  = exp_if;
        got_mem = exp_mem;
    endtask

    task automatic idle_cycle();
        logic gi, gm;
        drive_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gi, gm, p_if, p_mem;
        logic [5:0]  mem_pat, if_pat;
        logic [31:0] r_ia, r_ma, r_md;
        logic [3:0]  r_mw;

        for (int i = 0; i < 256; i++) ref_mem[i] = salt(8'(i));

        // Reset held with both requests active: everything must stay quiet.
        resetn = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        mem_req = 1'b1; mem_wen = 4'hF; mem_addr = 32'h40; mem_wdata = 32'h1234_5678;
        #2;
        chk_all_zero("in_reset");
        @(posedge clk); #1;
        chk_all_zero("in_reset_clk");
        if_req = 1'b0; mem_req = 1'b0;
        #2 resetn = 1'b1;

        // Lone ifetch, then a full-word store, a read-back and a partial store.
        drive_cycle(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0, 32'h0, gi, gm);
        idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, gi, gm);
        idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, gi, gm);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'b0101, 32'h0000_0040, 32'h1122_3344, gi, gm);
        drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, gi, gm);
        idle_cycle();

        // Contention for six cycles: ifetch must win only the fifth.
        mem_pat = '0; if_pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 32'h0000_0200, 1'b1, 4'h0, 32'h0000_0080, 32'h0, gi, gm);
            mem_pat[i] = mem_gnt;
            if_pat[i]  = if_gnt;
        end
        chk("starve_mem_pattern", 32'(mem_pat), 32'h2F);
        chk("starve_if_pattern", 32'(if_pat), 32'h10);
        idle_cycle();

        // Alternating owners every cycle with no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0080, 32'h0, gi, gm);
            else            drive_cycle(1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0, gi, gm);
        end
        idle_cycle();

        // Reset arrives while a mem read is in flight: its response is lost.
        drive_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0080, 32'h0, gi, gm);
        @(posedge clk); #1;
        resetn = 1'b0;
        exp_q.delete();
        starve = 0;
        if_req = 1'b1; mem_req = 1'b1;
        #3;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        chk_all_zero("mid_reset_clk");
        if_req = 1'b0; mem_req = 1'b0;
        #2 resetn = 1'b1;

        // First cycle after release is grantable; counter restarts from zero.
        mem_pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 32'h0000_1000, 1'b1, 4'h0, 32'h0000_0040, 32'h0, gi, gm);
            mem_pat[i] = mem_gnt;
        end
        chk("post_reset_mem_pattern", 32'(mem_pat), 32'h2F);
        idle_cycle();

        // Random traffic; each requester holds its request until granted.
        p_if = 1'b0; p_mem = 1'b0;
        r_ia = 32'h0; r_ma = 32'h0; r_md = 32'h0; r_mw = 4'h0;
        for (int i = 0; i < 500; i++) begin
            if (!p_if && $urandom_range(0, 99) < 60) begin
                p_if = 1'b1;
                r_ia = 32'h0000_3000 | (32'($urandom_range(0, 255)) << 2);
            end
            if (!p_mem && $urandom_range(0, 99) < 60) begin
                p_mem = 1'b1;
                r_ma = 32'h0000_3000 | (32'($urandom_range(0, 255)) << 2);
                r_mw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                r_md = $urandom;
            end
            drive_cycle(p_if, p_if ? r_ia : 32'h0, p_mem, p_mem ? r_mw : 4'h0,
                        p_mem ? r_ma : 32'h0, p_mem ? r_md : 32'h0, gi, gm);
            if (gi) p_if = 1'b0;
            if (gm) p_mem = 1'b0;
        end

        idle_cycle();
        idle_cycle();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
